// File: rtl/npu_exp_pkg.sv
// rtl/npu_exp_pkg.sv - shared types and constants for the exp_pipeline front end
//
// Purpose: operand/result widths, the Q0.31 result type and the requester tag
// type used by exp_arbiter and its tag FIFO. The tag type is sized for the
// largest supported requester count, so any NUM_REQ in 2..8 fits.
// Ports: none (package).

package npu_exp_pkg;

  localparam int EXP_DATA_W     = 32;
  localparam int EXP_INT_BITS_W = 4;
  localparam int EXP_MAX_REQ    = 8;
  localparam int EXP_TAG_W      = $clog2(EXP_MAX_REQ);

  // exp(x) result in Q0.31
  typedef logic [EXP_DATA_W-1:0] exp_q031_t;

  // Requester index carried alongside each in-flight operation
  typedef logic [EXP_TAG_W-1:0] exp_tag_t;

  // Next requester index after t, wrapping modulo n
  function automatic exp_tag_t exp_wrap_inc(input exp_tag_t t, input int n);
    return exp_tag_t'((int'(t) + 1) % n);
  endfunction

endpackage

// File: rtl/exp_tag_fifo.sv
// rtl/exp_tag_fifo.sv - in-order FIFO of requester tags for in-flight exp operations
//
// Purpose: remembers which requester issued each pipeline operation so results
// can be routed back in issue order. A push and a pop in the same cycle are
// accepted even when full, because the pop frees the slot being written.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_tag  write a tag (ignored when full without a concurrent pop)
//   pop, pop_tag    pop_tag shows the oldest entry; pop removes it
//   full, empty     occupancy flags
//   count           number of entries held (0..DEPTH)

module exp_tag_fifo
  import npu_exp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  exp_tag_t                   push_tag,
  input  logic                       pop,
  output exp_tag_t                   pop_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  exp_tag_t           mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_tag = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule

// File: rtl/exp_arbiter.sv
// rtl/exp_arbiter.sv - round-robin sharing of one exp_pipeline among NUM_REQ requesters
//
// Purpose: grants at most one requester per cycle into exp_pipeline, records the
// granted index in an in-order tag FIFO, and routes each pipeline result back to
// its requester as a one-cycle one-hot strobe. Adds one register stage on issue
// and one on return.
// Optional build macro: EXP_ARB_PRIO_EN - requester 0 wins whenever it is valid
// (pointer not advanced); requesters 1..NUM_REQ-1 share round-robin. Undefined:
// plain round-robin over all requesters.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready one-hot or zero)
//   req_x, req_int_bits          packed operands / Qm.n integer-bit counts
//   pipe_x, pipe_integer_bits,
//   pipe_input_valid             registered issue towards exp_pipeline
//   pipe_exp_x, pipe_output_valid  result from exp_pipeline
//   rsp_valid, rsp_data          one-hot result strobe and shared result bus
//   err_orphan                   sticky: result seen with no tag outstanding

module exp_arbiter
  import npu_exp_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16,
  parameter int DATA_W    = EXP_DATA_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]          req_x,
  input  logic [NUM_REQ*EXP_INT_BITS_W-1:0]  req_int_bits,
  output logic [DATA_W-1:0]                  pipe_x,
  output logic [EXP_INT_BITS_W-1:0]          pipe_integer_bits,
  output logic                               pipe_input_valid,
  input  logic [DATA_W-1:0]                  pipe_exp_x,
  input  logic                               pipe_output_valid,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic                               err_orphan
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  exp_tag_t                    ptr_q, ptr_d;
  logic [DATA_W-1:0]           pipe_x_q, pipe_x_d;
  logic [EXP_INT_BITS_W-1:0]   pipe_int_bits_q, pipe_int_bits_d;
  logic                        pipe_valid_q, pipe_valid_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;
  logic                        err_orphan_q, err_orphan_d;

  logic [EXP_MAX_REQ-1:0]      valid_ext;
  exp_tag_t                    cand;
  exp_tag_t                    gidx;
  logic                        found;
  logic                        grant;
  logic                        can_issue;
  logic                        pop;
  logic                        push;
  logic [DATA_W-1:0]           sel_x;
  logic [EXP_INT_BITS_W-1:0]   sel_ib;

  exp_tag_t                    pop_tag;
  logic                        tag_full;
  logic                        tag_empty;
  logic [CNT_W-1:0]            tag_count;

  // A result pops its tag in the same cycle, so a full FIFO can still accept
  // one new issue alongside it.
  assign pop       = pipe_output_valid & ~tag_empty;
  assign can_issue = (tag_count < CNT_W'(TAG_DEPTH)) | pop;
  // Redundant with can_issue; keeps the FIFO write interlocked on its own flag
  assign push      = grant & (~tag_full | pop);

  // Arbitration: first valid requester at or after ptr_q, wrapping
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
`ifdef EXP_ARB_PRIO_EN
    // Requester 0 is handled by the priority override below
    valid_ext[0] = 1'b0;
`endif
    cand  = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = exp_tag_t'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && valid_ext[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
`ifdef EXP_ARB_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
      gidx  = '0;
    end
`endif
    // Gating with rst keeps req_ready low for the whole reset window
    grant = found & can_issue & ~rst;

    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = exp_wrap_inc(gidx, NUM_REQ);
    end
`ifdef EXP_ARB_PRIO_EN
    if (req_valid[0]) begin
      ptr_d = ptr_q;
    end
`endif

    req_ready = '0;
    sel_x     = '0;
    sel_ib    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx == exp_tag_t'(k)) begin
        req_ready[k] = grant;
        sel_x        = req_x[k*DATA_W +: DATA_W];
        sel_ib       = req_int_bits[k*EXP_INT_BITS_W +: EXP_INT_BITS_W];
      end
    end
  end

  // Issue and return registers
  always_comb begin
    pipe_valid_d    = grant;
    pipe_x_d        = pipe_x_q;
    pipe_int_bits_d = pipe_int_bits_q;
    if (grant) begin
      pipe_x_d        = sel_x;
      pipe_int_bits_d = sel_ib;
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_data_d = pipe_exp_x;
      for (int k = 0; k < NUM_REQ; k++) begin
        rsp_valid_d[k] = (pop_tag == exp_tag_t'(k));
      end
    end

    err_orphan_d = err_orphan_q | (pipe_output_valid & tag_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      pipe_x_q        <= '0;
      pipe_int_bits_q <= '0;
      pipe_valid_q    <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_orphan_q    <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      pipe_x_q        <= pipe_x_d;
      pipe_int_bits_q <= pipe_int_bits_d;
      pipe_valid_q    <= pipe_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      err_orphan_q    <= err_orphan_d;
    end
  end

  assign pipe_x            = pipe_x_q;
  assign pipe_integer_bits = pipe_int_bits_q;
  assign pipe_input_valid  = pipe_valid_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign err_orphan        = err_orphan_q;

  exp_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (gidx),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

endmodule

// File: tb/tb_exp_arbiter.sv
// tb/tb_exp_arbiter.sv - directed scoreboard bench for exp_arbiter with a behavioural exp_pipeline

module tb_exp_arbiter;

  localparam int NR = 4;
  localparam int TD = 16;
  localparam int DW = 32;
  localparam int PL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_x = '0;
  logic [NR*4-1:0]   req_int_bits = '0;
  logic [DW-1:0]     pipe_x;
  logic [3:0]        pipe_integer_bits;
  logic              pipe_input_valid;
  logic [DW-1:0]     pipe_exp_x;
  logic              pipe_output_valid;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              err_orphan;

  exp_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_x             (req_x),
    .req_int_bits      (req_int_bits),
    .pipe_x            (pipe_x),
    .pipe_integer_bits (pipe_integer_bits),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_exp_x        (pipe_exp_x),
    .pipe_output_valid (pipe_output_valid),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .err_orphan        (err_orphan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int rsp_cnt = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic logic [31:0] golden(input logic [31:0] x);
    case (x)
      32'h84000000: return 32'h4DA33613;
      32'h80CCCCCD: return 32'h73E0B69D;
      32'h8199999A: return 32'h68DB8BAC;
      32'h82666666: return 32'h5F4FB460;
      32'h83333333: return 32'h55E63A3E;
      default:      return x ^ 32'h1234_5678;
    endcase
  endfunction

  // Behavioural exp_pipeline: fixed latency PL, optional stall with single releases
  logic        stall = 1'b0;
  logic        rel_tgl = 1'b0;
  logic        rel_seen = 1'b0;
  logic        m_ov = 1'b0;
  logic [31:0] m_data = '0;
  logic        inj_ov = 1'b0;
  logic [31:0] inj_data = '0;
  logic [31:0] mq_x[$];
  int          mq_t[$];
  int          mcyc = 0;

  assign pipe_output_valid = m_ov | inj_ov;
  assign pipe_exp_x        = inj_ov ? inj_data : m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_x.delete();
      mq_t.delete();
      m_ov   <= 1'b0;
      m_data <= '0;
    end else begin
      m_ov <= 1'b0;
      if (mq_t.size() > 0 && (mcyc - mq_t[0]) >= PL - 1 && (!stall || rel_tgl != rel_seen)) begin
        m_ov     <= 1'b1;
        m_data   <= golden(mq_x[0]);
        rel_seen <= rel_tgl;
        void'(mq_x.pop_front());
        void'(mq_t.pop_front());
      end
      if (pipe_input_valid) begin
        mq_x.push_back(pipe_x);
        mq_t.push_back(mcyc);
      end
      mcyc <= mcyc + 1;
    end
  end

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
    int            t;
    bit            lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && rsp_valid !== '0) begin
      rsp_cnt++;
      chk(32'(sb.size() > 0), 32'd1, "rsp_expected");
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(32'(rsp_valid), 32'(e.oh), "rsp_valid");
        chk(rsp_data, e.data, "rsp_data");
        if (e.lat) chk(32'(ncyc - e.t), 32'(PL + 2), "latency");
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] x, input logic [3:0] ib);
    req_x[i*DW +: DW]      = x;
    req_int_bits[i*4 +: 4] = ib;
  endtask

  // Check req_ready for the current cycle and queue the results it implies
  task automatic cyc_expect(input logic [NR-1:0] exp_rdy, input bit lat, input string tag);
    exp_t e;
    @(negedge clk);
    chk(32'(req_ready), 32'(exp_rdy), tag);
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i]) begin
        e.oh   = NR'(1 << i);
        e.data = golden(req_x[i*DW +: DW]);
        e.t    = ncyc;
        e.lat  = lat;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    req_valid = '0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(32'(sb.size()), 32'd0, tag);
  endtask

  task automatic check_zero(input string tag);
    chk(32'(req_ready), 32'd0, {tag, "_req_ready"});
    chk(32'(pipe_input_valid), 32'd0, {tag, "_pipe_iv"});
    chk(pipe_x, 32'd0, {tag, "_pipe_x"});
    chk(32'(pipe_integer_bits), 32'd0, {tag, "_pipe_ib"});
    chk(32'(rsp_valid), 32'd0, {tag, "_rsp_valid"});
    chk(rsp_data, 32'd0, {tag, "_rsp_data"});
    chk(32'(err_orphan), 32'd0, {tag, "_err_orphan"});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_zero(tag);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_four();
    set_req(0, 32'h80CCCCCD, 4'd4);
    set_req(1, 32'h8199999A, 4'd4);
    set_req(2, 32'h82666666, 4'd4);
    set_req(3, 32'h83333333, 4'd4);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;

    // Reset with every requester valid
    load_four();
    req_valid = '1;
    #1;
    do_reset("rst0");
    req_valid = '0;

    // Single request from requester 2
    set_req(2, 32'h84000000, 4'd4);
    req_valid = 4'b0100;
    r0 = rsp_cnt;
    cyc_expect(4'b0100, 1'b1, "t1_ready");
    req_valid = '0;
    @(negedge clk);
    chk(32'(pipe_input_valid), 32'd1, "t1_pipe_iv");
    chk(pipe_x, 32'h84000000, "t1_pipe_x");
    chk(32'(pipe_integer_bits), 32'd4, "t1_pipe_ib");
    @(posedge clk);
    #1;
    drain("t1_drain");
    chk(32'(rsp_cnt - r0), 32'd1, "t1_count");
    chk(pipe_x, 32'h84000000, "t1_hold_x");
    chk(32'(pipe_input_valid), 32'd0, "t1_idle_iv");

    // All four valid continuously: 0,1,2,3,0,...
    do_reset("rst1");
    load_four();
    req_valid = '1;
    for (int c = 0; c < 8; c++) cyc_expect(NR'(1 << (c % 4)), 1'b1, "t2_rr");
    drain("t2_drain");

    // Sparse patterns; pointer is back at 0 here
    req_valid = 4'b1010;
    cyc_expect(4'b0010, 1'b1, "t2b_a");
    cyc_expect(4'b1000, 1'b1, "t2b_b");
    cyc_expect(4'b0010, 1'b1, "t2b_c");
    req_valid = 4'b0011;
    cyc_expect(4'b0001, 1'b1, "t2b_wrap");
    cyc_expect(4'b0010, 1'b1, "t2b_next");
    drain("t2b_drain");

    // Stalled pipeline: 16 tags fill the FIFO, then one pop admits one issue
    do_reset("rst2");
    stall = 1'b1;
    req_valid = 4'b0001;
    for (int c = 0; c < TD; c++) cyc_expect(4'b0001, 1'b0, "t3_fill");
    for (int c = 0; c < 3; c++) cyc_expect(4'b0000, 1'b0, "t3_full");
    rel_tgl = ~rel_tgl;
    cyc_expect(4'b0000, 1'b0, "t3_pre");
    cyc_expect(4'b0001, 1'b0, "t3_pop_grant");
    cyc_expect(4'b0000, 1'b0, "t3_refull");
    stall = 1'b0;
    drain("t3_drain");

    // Orphan result
    chk(32'(err_orphan), 32'd0, "t4_pre");
    inj_data = 32'hDEADBEEF;
    inj_ov = 1'b1;
    @(posedge clk);
    #1;
    inj_ov = 1'b0;
    @(negedge clk);
    chk(32'(err_orphan), 32'd1, "t4_set");
    chk(32'(rsp_valid), 32'd0, "t4_no_rsp");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(32'(err_orphan), 32'd1, "t4_sticky");
    chk(32'(rsp_valid), 32'd0, "t4_no_rsp2");
    @(posedge clk);
    #1;
    do_reset("t4_rst");
    chk(32'(err_orphan), 32'd0, "t4_cleared");

    // Reset with five requests in flight
    load_four();
    req_valid = '1;
    for (int c = 0; c < 5; c++) cyc_expect(NR'(1 << (c % 4)), 1'b0, "t5_issue");
    do_reset("t5_rst");
    r0 = rsp_cnt;
    cyc_expect(4'b0001, 1'b1, "t5_first");
    drain("t5_drain");
    chk(32'(rsp_cnt - r0), 32'd1, "t5_no_stale");

    // Requesters 0 and 1 contending
    do_reset("rst6");
    req_valid = 4'b0011;
`ifdef EXP_ARB_PRIO_EN
    for (int c = 0; c < 4; c++) cyc_expect(4'b0001, 1'b1, "t6_prio");
`else
    for (int c = 0; c < 4; c++) cyc_expect(NR'(1 << (c % 2)), 1'b1, "t6_rr");
`endif
    req_valid = 4'b0010;
    cyc_expect(4'b0010, 1'b1, "t6_drop0");
    drain("t6_drain");
    chk(32'(err_orphan), 32'd0, "final_orphan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exp_arbiter.md
Name: exp_arbiter

Overview:
- Shares one `exp_pipeline` instance between NUM_REQ requesters, e.g. softmax lanes.
- Round-robin arbitration issues at most one request per cycle into the pipeline.
- Each issued requester ID is tracked in an in-order tag FIFO.
- Each pipeline result is routed back to the requester that issued it.
- Sits between the activation/softmax control logic and `exp_pipeline`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_DEPTH, 16, max in-flight requests; must be at least pipeline latency + 2; power of two.
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept
- req_x  in  NUM_REQ*DATA_W  packed operands; requester i occupies [i*DATA_W +: DATA_W]
- req_int_bits  in  NUM_REQ*4  packed integer-bit counts for the Qm.n input format
- pipe_x  out  DATA_W  operand to `exp_pipeline`.x
- pipe_integer_bits  out  4  to `exp_pipeline`.integer_bits
- pipe_input_valid  out  1  to `exp_pipeline`.input_valid
- pipe_exp_x  in  DATA_W  from `exp_pipeline`.exp_x (Q0.31)
- pipe_output_valid  in  1  from `exp_pipeline`.output_valid
- rsp_valid  out  NUM_REQ  one-hot result strobe
- rsp_data  out  DATA_W  result, shared by all requesters
- err_orphan  out  1  sticky; set on a result arriving with no tag outstanding

Behaviour:
- Reset (async, rst=1):
  - all outputs 0: req_ready, pipe_input_valid, pipe_x, pipe_integer_bits, rsp_valid, rsp_data, err_orphan.
  - RR pointer resets to 0; tag FIFO is emptied.
  - `exp_pipeline` shares the same rst, so no stale results survive a reset.
- Arbitration (combinational, each cycle):
  - Search starts at the RR pointer and wraps modulo NUM_REQ.
  - The first requester with req_valid=1 is granted only if can_issue=1.
  - can_issue = (tag_count < TAG_DEPTH) OR (pop happening this cycle).
  - req_ready is one-hot (or all zero) and asserted only for the granted requester.
  - A transfer occurs when req_valid & req_ready.
  - Requesters hold req_x/req_int_bits stable while valid and not ready.
- RR pointer: on a grant, the next value is granted+1 mod NUM_REQ; with no grant it is unchanged.
- Issue register: on a grant, at the next clk edge:
  - pipe_x/pipe_integer_bits take the granted operand;
  - pipe_input_valid=1;
  - the granted index is pushed into the tag FIFO.
  - With no grant, pipe_input_valid=0 and the data registers hold their values.
  - Back-to-back issue at one per cycle is supported.
- Return path:
  - On pipe_output_valid=1 with the FIFO non-empty, pop the tag.
  - Next edge: rsp_data=pipe_exp_x, rsp_valid = one-hot(tag) for one cycle.
  - Added latency is 1 cycle on issue plus 1 cycle on return, on top of the pipeline latency.
- Simultaneous push and pop in one cycle: tag_count is unchanged; legal when the FIFO is full (pop frees the slot).
- Orphan result: pipe_output_valid with the FIFO empty sets err_orphan (held until rst); no rsp_valid, no pop.
- Requesters must always accept rsp_valid; there is no response backpressure.
- Result ordering is strictly issue order; FIFO pointers wrap modulo TAG_DEPTH.

Optional Feature:
- Macro: EXP_ARB_PRIO_EN.
- Defined: requester 0 has strict priority. When req_valid[0]=1 and can_issue=1, it is granted regardless of the RR pointer, and the RR pointer does not advance. Requesters 1..NUM_REQ-1 are round-robin among themselves.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Shared package npu_exp_pkg:
  - EXP_DATA_W=32, EXP_INT_BITS_W=4;
  - the Q0.31 result typedef;
  - typedef for the requester tag, width $clog2(NUM_REQ).
- One sub-module, exp_tag_fifo:
  - synchronous FIFO, width = tag width, depth TAG_DEPTH;
  - push/pop/full/empty/count outputs;
  - simultaneous push+pop when full is allowed.

Test Plan:
- Single requester: req 2 sends x=0x84000000 (-0.5 Q4.27), int_bits=4 -> exactly one rsp_valid=4'b0100 with rsp_data within 0x0147AE14 of 0x4DA33613; latency = pipeline latency + 2.
- All four valid continuously, each with a different x (0x80CCCCCD, 0x8199999A, 0x82666666, 0x83333333) -> grants cycle 0,1,2,3,0...; each rsp_valid bit carries its own golden result (0x73E0B69D, 0x68DB8BAC, 0x5F4FB460, 0x55E63A3E ±tolerance).
- Stalled pipeline model (output_valid withheld) -> after 16 issues req_ready stays 0; first output_valid allows one new grant in the same cycle.
- Inject pipe_output_valid with FIFO empty -> err_orphan=1 and stays 1, rsp_valid stays 0; rst=1 clears it.
- Assert rst with 5 requests in flight -> all outputs 0 immediately; after release the first grant goes to requester 0 and no stale rsp_valid appears.
- EXP_ARB_PRIO_EN defined, req 0 and req 1 valid continuously -> only req 0 granted; drop req 0 -> req 1 granted the next cycle.
